hash_batch_route_node: RTL and testbench
========================================

HASH_BATCH_ROUTE_NODE -- requirements
Module: hash_batch_route_node

Interface
REQ-001 SHALL have parameter IDX, default 0, meaning the node index; the node serves PE indices IDX*NUM_LOCAL .. IDX*NUM_LOCAL+NUM_LOCAL-1.
REQ-002 SHALL have parameter NUM_LOCAL, default 1, meaning the number of local PE channels; the value SHALL be a power of 2 and no greater than 2^NUM_JOB_PE_LOG2.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, meaning the entries per local channel FIFO; the value SHALL be at least 1. LW = $clog2(FIFO_DEPTH+1).
REQ-004 SHALL have parameter PIPED, default 0, meaning: 0 selects a combinational pass-through to next, 1 selects a registered 2-entry skid buffer.
REQ-005 SHALL have parameter PAYLOAD_W, default HASH_ISSUE_WIDTH*(1+ADDR_WIDTH+META_MATCH_LEN_WIDTH+1), meaning the packed history_valid/history_addr/meta_len/can_ext width.
REQ-006 clk  in  1  clock; all state changes on the rising edge.
REQ-007 rst_n  in  1  reset, asynchronous and active-low.
REQ-008 i_valid / i_ready  in / out  1 / 1  upstream handshake.
REQ-009 i_head_addr  in  ADDR_WIDTH  batch head address, carrying the destination PE index.
REQ-010 i_payload  in  PAYLOAD_W  batch body; i_delim  in  1  job delimiter.
REQ-011 o_local_valid  out  NUM_LOCAL  one valid bit per local channel; o_local_ready  in  NUM_LOCAL  one ready bit per local channel.
REQ-012 o_local_head_addr  out  NUM_LOCAL*ADDR_WIDTH; o_local_payload  out  NUM_LOCAL*PAYLOAD_W; o_local_delim  out  NUM_LOCAL; all packed with channel 0 in the LSBs.
REQ-013 o_local_level  out  NUM_LOCAL*LW  FIFO occupancy of each channel.
REQ-014 o_next_valid / o_next_ready  out / in  1 / 1; o_next_head_addr  out  ADDR_WIDTH; o_next_payload  out  PAYLOAD_W; o_next_delim  out  1.

Function
REQ-015 SHALL decode pe = i_head_addr[JOB_LEN_LOG2 +: NUM_JOB_PE_LOG2]; the batch is local when pe / NUM_LOCAL == IDX, and the local channel ch = pe % NUM_LOCAL.
REQ-016 SHALL route a local batch only to channel ch, and a non-local batch only to next; a batch SHALL never be duplicated or dropped.
REQ-017 SHALL drive i_ready = !full[ch] for a local batch and next_ready for a non-local batch; i_ready SHALL be combinationally independent of o_local_ready.
REQ-018 SHALL push one entry into FIFO[ch] in the same cycle that i_valid && i_ready && local; the stored entry is {head_addr, payload, delim}.
REQ-019 Each FIFO SHALL be first-word-fall-through: o_local_valid[c] = level[c] != 0, with the head entry presented; a pop occurs on o_local_valid[c] && o_local_ready[c].
REQ-020 FIFO minimum latency SHALL be 1 cycle from push to o_local_valid.
REQ-021 Full means level == FIFO_DEPTH; when full, i_ready SHALL be 0 for that channel even if a pop occurs in the same cycle.
REQ-022 A simultaneous push and pop on a non-full, non-empty FIFO SHALL leave level unchanged and preserve order.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH, which need not be a power of 2.
REQ-024 With PIPED=0, o_next_* SHALL equal the input fields, o_next_valid = i_valid && !local, and next_ready = o_next_ready.
REQ-025 With PIPED=1, the next path SHALL be a 2-entry skid buffer with 1-cycle latency and full throughput; next_ready SHALL be a registered signal, true while fewer than 2 entries are held.
REQ-026 Output payloads SHALL hold stable while valid is high and ready is low, on every output.
REQ-027 Per-channel ordering SHALL be preserved; no ordering between channels, or between local and next, is guaranteed.

Reset
REQ-028 On rst_n low, asynchronously: all FIFO levels and pointers 0, o_local_valid = 0, o_local_level = 0, skid buffer empty, o_next_valid = 0 (PIPED=1).
REQ-029 Data registers SHALL NOT require reset; when the corresponding valid is 0, outputs are don't-care.
REQ-030 Reset asserted mid-transfer SHALL discard all buffered batches; after release, i_ready SHALL be 1 for local destinations in the first cycle.

Verification (bench config: NUM_JOB_PE_LOG2=2, IDX=1, NUM_LOCAL=2, FIFO_DEPTH=3, PIPED=1)
REQ-031 Push pe=2 and then pe=3, with o_local_ready=2'b11 -> each appears on channel 0 and channel 1 respectively, 1 cycle after its own push; o_next_valid stays 0.
REQ-032 Push 4 batches for pe=2 with o_local_ready[0]=0 -> o_local_level[0] steps 1,2,3; i_ready=0 on the 4th; releasing ready drains the entries in order.
REQ-033 With level[0]=3, assert o_local_ready[0] and push pe=2 in the same cycle -> i_ready=0, level[0] becomes 2.
REQ-034 Stream pe=0 and pe=1 batches every cycle with o_next_ready=1 -> o_next_valid at 1-cycle latency, 1 batch/cycle; drop o_next_ready for 3 cycles -> no loss and stable payload.
REQ-035 Push pe=3 with o_local_ready[1]=0 while o_next_ready=0 -> the pe=3 batch is accepted; a following pe=0 batch stalls only after 2 batches are buffered on next.
REQ-036 Fill both FIFOs, assert rst_n=0 for 1 cycle -> all valids and levels 0 immediately; the first post-reset batch is delivered correctly.

Source files
------------

// File: rtl/hash_batch_route_node.sv
// hash_batch_route_node
//   One node of a daisy-chained batch router. Each incoming batch carries its
//   destination PE index in the head address. Batches for the PEs served by
//   this node go into a per-channel first-word-fall-through FIFO. All other
//   batches are forwarded to the next node, either combinationally
//   (PIPED=0) or through a registered 2-entry skid buffer (PIPED=1).
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_valid/i_ready             upstream handshake
//   i_head_addr/i_payload/
//   i_delim                     incoming batch (head address, body, job delimiter)
//   o_local_valid/o_local_ready per-channel handshake, channel 0 in the LSBs
//   o_local_head_addr/
//   o_local_payload/
//   o_local_delim               per-channel FIFO head entry, packed with channel 0 in the LSBs
//   o_local_level               per-channel FIFO occupancy, packed
//   o_next_valid/o_next_ready   downstream handshake to the next node
//   o_next_head_addr/
//   o_next_payload/
//   o_next_delim                forwarded batch
module hash_batch_route_node #(
    parameter int ADDR_WIDTH           = 16,
    parameter int JOB_LEN_LOG2         = 4,
    parameter int NUM_JOB_PE_LOG2      = 2,
    parameter int HASH_ISSUE_WIDTH     = 4,
    parameter int META_MATCH_LEN_WIDTH = 6,
    parameter int IDX                  = 0,
    parameter int NUM_LOCAL            = 1,
    parameter int FIFO_DEPTH           = 2,
    parameter int PIPED                = 0,
    parameter int PAYLOAD_W            = HASH_ISSUE_WIDTH*(1+ADDR_WIDTH+META_MATCH_LEN_WIDTH+1),
    parameter int LW                   = $clog2(FIFO_DEPTH+1)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_valid,
    output logic                            i_ready,
    input  logic [ADDR_WIDTH-1:0]           i_head_addr,
    input  logic [PAYLOAD_W-1:0]            i_payload,
    input  logic                            i_delim,
    output logic [NUM_LOCAL-1:0]            o_local_valid,
    input  logic [NUM_LOCAL-1:0]            o_local_ready,
    output logic [NUM_LOCAL*ADDR_WIDTH-1:0] o_local_head_addr,
    output logic [NUM_LOCAL*PAYLOAD_W-1:0]  o_local_payload,
    output logic [NUM_LOCAL-1:0]            o_local_delim,
    output logic [NUM_LOCAL*LW-1:0]         o_local_level,
    output logic                            o_next_valid,
    input  logic                            o_next_ready,
    output logic [ADDR_WIDTH-1:0]           o_next_head_addr,
    output logic [PAYLOAD_W-1:0]            o_next_payload,
    output logic                            o_next_delim
);

    localparam int EW         = ADDR_WIDTH + PAYLOAD_W + 1;
    localparam int PW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CHW        = (NUM_LOCAL > 1) ? $clog2(NUM_LOCAL) : 1;
    localparam int LOCAL_LOG2 = $clog2(NUM_LOCAL);

    // Pointer advance with wrap at FIFO_DEPTH, which may not be a power of 2.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        if (32'(ptr) == FIFO_DEPTH - 1) begin
            next_ptr = {PW{1'b0}};
        end else begin
            next_ptr = ptr + {{(PW-1){1'b0}}, 1'b1};
        end
    endfunction

    logic [NUM_JOB_PE_LOG2-1:0] pe_s;
    logic                       local_s;
    logic [CHW-1:0]             ch_s;
    logic [EW-1:0]              in_entry_s;
    logic                       next_ready_s;
    logic                       local_full_s;

    logic [LW-1:0]              level_r  [NUM_LOCAL];
    logic [PW-1:0]              wr_ptr_r [NUM_LOCAL];
    logic [PW-1:0]              rd_ptr_r [NUM_LOCAL];
    logic [EW-1:0]              mem_r    [NUM_LOCAL][FIFO_DEPTH];
    logic [NUM_LOCAL-1:0]       full_s;
    logic [NUM_LOCAL-1:0]       push_s;
    logic [NUM_LOCAL-1:0]       pop_s;

    // Destination decode: PE index, local/forward decision, local channel.
    always_comb begin
        pe_s       = i_head_addr[JOB_LEN_LOG2 +: NUM_JOB_PE_LOG2];
        local_s    = ((32'(pe_s) >> LOCAL_LOG2) == 32'(IDX));
        ch_s       = CHW'(32'(pe_s) & 32'(NUM_LOCAL - 1));
        in_entry_s = {i_head_addr, i_payload, i_delim};
    end

    // Per-channel full, push and pop strobes; full depends only on the level
    // register so i_ready never sees o_local_ready.
    always_comb begin
        full_s       = {NUM_LOCAL{1'b0}};
        push_s       = {NUM_LOCAL{1'b0}};
        pop_s        = {NUM_LOCAL{1'b0}};
        local_full_s = 1'b0;
        for (int c = 0; c < NUM_LOCAL; c++) begin
            full_s[c] = (level_r[c] == LW'(FIFO_DEPTH));
            pop_s[c]  = (level_r[c] != {LW{1'b0}}) && o_local_ready[c];
            if (ch_s == CHW'(c)) begin
                local_full_s = full_s[c];
                push_s[c]    = i_valid && local_s && !full_s[c];
            end else begin
                push_s[c]    = 1'b0;
            end
        end
    end

    // Upstream ready: selected channel's space or the next path's ready.
    always_comb begin
        if (local_s) begin
            i_ready = !local_full_s;
        end else begin
            i_ready = next_ready_s;
        end
    end

    // FIFO pointers and levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_LOCAL; c++) begin
                level_r[c]  <= {LW{1'b0}};
                wr_ptr_r[c] <= {PW{1'b0}};
                rd_ptr_r[c] <= {PW{1'b0}};
            end
        end else begin
            for (int c = 0; c < NUM_LOCAL; c++) begin
                if (push_s[c]) begin
                    wr_ptr_r[c] <= next_ptr(wr_ptr_r[c]);
                end
                if (pop_s[c]) begin
                    rd_ptr_r[c] <= next_ptr(rd_ptr_r[c]);
                end
                case ({push_s[c], pop_s[c]})
                    2'b10:   level_r[c] <= level_r[c] + {{(LW-1){1'b0}}, 1'b1};
                    2'b01:   level_r[c] <= level_r[c] - {{(LW-1){1'b0}}, 1'b1};
                    default: level_r[c] <= level_r[c];
                endcase
            end
        end
    end

    // FIFO storage; contents are meaningless while the level is zero.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_LOCAL; c++) begin
            if (push_s[c]) begin
                mem_r[c][wr_ptr_r[c]] <= in_entry_s;
            end
        end
    end

    // First-word-fall-through presentation of each FIFO head.
    always_comb begin
        for (int c = 0; c < NUM_LOCAL; c++) begin
            o_local_valid[c] = (level_r[c] != {LW{1'b0}});
            {o_local_head_addr[c*ADDR_WIDTH +: ADDR_WIDTH],
             o_local_payload[c*PAYLOAD_W +: PAYLOAD_W],
             o_local_delim[c]} = mem_r[c][rd_ptr_r[c]];
            o_local_level[c*LW +: LW] = level_r[c];
        end
    end

    if (PIPED != 0) begin : g_skid
        logic [EW-1:0] sk_mem_r [2];
        logic          sk_wr_r;
        logic          sk_rd_r;
        logic [1:0]    sk_cnt_r;
        logic [1:0]    sk_cnt_s;
        logic          sk_rdy_r;
        logic          sk_push_s;
        logic          sk_pop_s;

        // Skid buffer strobes and next occupancy.
        always_comb begin
            sk_push_s = i_valid && !local_s && sk_rdy_r;
            sk_pop_s  = (sk_cnt_r != 2'd0) && o_next_ready;
            case ({sk_push_s, sk_pop_s})
                2'b10:   sk_cnt_s = sk_cnt_r + 2'd1;
                2'b01:   sk_cnt_s = sk_cnt_r - 2'd1;
                default: sk_cnt_s = sk_cnt_r;
            endcase
        end

        // Skid buffer control; ready is registered from the next occupancy.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sk_cnt_r <= 2'd0;
                sk_wr_r  <= 1'b0;
                sk_rd_r  <= 1'b0;
                sk_rdy_r <= 1'b1;
            end else begin
                sk_cnt_r <= sk_cnt_s;
                sk_rdy_r <= (sk_cnt_s < 2'd2);
                if (sk_push_s) begin
                    sk_wr_r <= ~sk_wr_r;
                end
                if (sk_pop_s) begin
                    sk_rd_r <= ~sk_rd_r;
                end
            end
        end

        // Skid buffer storage.
        always_ff @(posedge clk) begin
            if (sk_push_s) begin
                sk_mem_r[sk_wr_r] <= in_entry_s;
            end
        end

        assign next_ready_s = sk_rdy_r;
        assign o_next_valid = (sk_cnt_r != 2'd0);
        assign {o_next_head_addr, o_next_payload, o_next_delim} = sk_mem_r[sk_rd_r];
    end else begin : g_pass
        assign next_ready_s     = o_next_ready;
        assign o_next_valid     = i_valid && !local_s;
        assign o_next_head_addr = i_head_addr;
        assign o_next_payload   = i_payload;
        assign o_next_delim     = i_delim;
    end

endmodule

// File: tb/tb_hash_batch_route_node.sv
module tb_hash_batch_route_node;

    localparam int AW  = 16;
    localparam int PLW = 16;
    localparam int EW  = AW + PLW + 1;
    localparam int LW  = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            i_valid;
    logic            i_ready;
    logic [AW-1:0]   i_head_addr;
    logic [PLW-1:0]  i_payload;
    logic            i_delim;
    logic [1:0]      o_local_valid;
    logic [1:0]      o_local_ready;
    logic [2*AW-1:0] o_local_head_addr;
    logic [2*PLW-1:0] o_local_payload;
    logic [1:0]      o_local_delim;
    logic [2*LW-1:0] o_local_level;
    logic            o_next_valid;
    logic            o_next_ready;
    logic [AW-1:0]   o_next_head_addr;
    logic [PLW-1:0]  o_next_payload;
    logic            o_next_delim;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: one queue per local PE channel, one for the next path.
    logic [EW-1:0] lq0 [$];
    logic [EW-1:0] lq1 [$];
    logic [EW-1:0] nq  [$];

    hash_batch_route_node #(
        .ADDR_WIDTH(AW), .JOB_LEN_LOG2(4), .NUM_JOB_PE_LOG2(2),
        .IDX(1), .NUM_LOCAL(2), .FIFO_DEPTH(3), .PIPED(1), .PAYLOAD_W(PLW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_valid(i_valid), .i_ready(i_ready),
        .i_head_addr(i_head_addr), .i_payload(i_payload), .i_delim(i_delim),
        .o_local_valid(o_local_valid), .o_local_ready(o_local_ready),
        .o_local_head_addr(o_local_head_addr), .o_local_payload(o_local_payload),
        .o_local_delim(o_local_delim), .o_local_level(o_local_level),
        .o_next_valid(o_next_valid), .o_next_ready(o_next_ready),
        .o_next_head_addr(o_next_head_addr), .o_next_payload(o_next_payload),
        .o_next_delim(o_next_delim)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, compare outputs with the reference, advance it.
    task automatic step(input logic v, input int pe, input logic [1:0] lr, input logic nr);
        logic [AW-1:0]  a;
        logic [PLW-1:0] p;
        logic           d;
        logic           loc;
        int             ch;
        logic           exp_rdy;
        a = AW'($urandom);
        a[5:4] = 2'(pe);
        p = PLW'($urandom);
        d = 1'($urandom);
        @(negedge clk);
        i_valid = v; i_head_addr = a; i_payload = p; i_delim = d;
        o_local_ready = lr; o_next_ready = nr;
        #1;
        loc = ((pe / 2) == 1);
        ch  = pe % 2;
        if (loc) exp_rdy = (ch == 0) ? (lq0.size() < 3) : (lq1.size() < 3);
        else     exp_rdy = (nq.size() < 2);
        check("i_ready", 64'(i_ready), 64'(exp_rdy));
        check("local_valid", 64'(o_local_valid), 64'({lq1.size() != 0, lq0.size() != 0}));
        check("level0", 64'(o_local_level[1:0]), 64'(lq0.size()));
        check("level1", 64'(o_local_level[3:2]), 64'(lq1.size()));
        if (lq0.size() != 0)
            check("local_data0", 64'({o_local_head_addr[15:0], o_local_payload[15:0], o_local_delim[0]}), 64'(lq0[0]));
        if (lq1.size() != 0)
            check("local_data1", 64'({o_local_head_addr[31:16], o_local_payload[31:16], o_local_delim[1]}), 64'(lq1[0]));
        check("next_valid", 64'(o_next_valid), 64'(nq.size() != 0));
        if (nq.size() != 0)
            check("next_data", 64'({o_next_head_addr, o_next_payload, o_next_delim}), 64'(nq[0]));
        if (lq0.size() != 0 && lr[0]) void'(lq0.pop_front());
        if (lq1.size() != 0 && lr[1]) void'(lq1.pop_front());
        if (nq.size() != 0 && nr)     void'(nq.pop_front());
        if (v && exp_rdy) begin
            if (!loc)         nq.push_back({a, p, d});
            else if (ch == 0) lq0.push_back({a, p, d});
            else              lq1.push_back({a, p, d});
        end
        @(posedge clk);
    endtask

    // Reset for one cycle; everything buffered must vanish immediately.
    task automatic do_reset();
        @(negedge clk);
        i_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_local_valid", 64'(o_local_valid), 64'd0);
        check("rst_level", 64'(o_local_level), 64'd0);
        check("rst_next_valid", 64'(o_next_valid), 64'd0);
        lq0.delete(); lq1.delete(); nq.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; i_valid = 1'b0; i_head_addr = '0; i_payload = '0; i_delim = 1'b0;
        o_local_ready = 2'b00; o_next_ready = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        // Local delivery to each channel with 1-cycle latency.
        step(1'b1, 2, 2'b11, 1'b1);
        step(1'b1, 3, 2'b11, 1'b1);
        repeat (2) step(1'b0, 0, 2'b11, 1'b1);

        // Fill channel 0, overflow attempt, full with same-cycle pop, drain.
        repeat (4) step(1'b1, 2, 2'b10, 1'b1);
        step(1'b1, 2, 2'b11, 1'b1);
        repeat (4) step(1'b0, 2, 2'b11, 1'b1);

        // Forwarding stream, then a 3-cycle downstream stall.
        for (int i = 0; i < 8; i++) step(1'b1, i % 2, 2'b11, 1'b1);
        repeat (3) step(1'b1, 0, 2'b11, 1'b0);
        repeat (4) step(1'b0, 0, 2'b11, 1'b1);

        // Local batch accepted while next stalls; next fills at 2 entries.
        step(1'b1, 3, 2'b01, 1'b0);
        repeat (3) step(1'b1, 0, 2'b01, 1'b0);
        repeat (3) step(1'b0, 0, 2'b11, 1'b1);

        // Both FIFOs full, then reset, then one clean batch.
        for (int i = 0; i < 6; i++) step(1'b1, 2 + (i % 2), 2'b00, 1'b1);
        step(1'b1, 1, 2'b00, 1'b0);
        do_reset();
        step(1'b1, 2, 2'b11, 1'b1);
        step(1'b0, 0, 2'b11, 1'b1);

        // Randomized traffic with an occasional mid-stream reset.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            step(1'($urandom), $urandom_range(0, 3), 2'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
